// File: rtl/seq_div4.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define SEQDIV_DBZ_EARLY_EN to finish divide-by-zero in one cycle.
module seq_div4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   pn;
  logic [WIDTH:0]   t;
  logic             qb;
  logic [WIDTH-1:0] pnx;
  logic [WIDTH-1:0] qnx;

  // Partial remainder never exceeds the divisor, so WIDTH bits suffice
  // for the stored value; only the trial subtraction needs the extra bit.
  always_comb begin
    pn  = {p, a[WIDTH-1]};
    t   = pn - {1'b0, d};
    qb  = ~t[WIDTH];
    pnx = qb ? t[WIDTH-1:0] : pn[WIDTH-1:0];
    qnx = {q[WIDTH-2:0], qb};
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      d         <= '0;
      p         <= '0;
      q         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a <= a << 1;
          p <= pnx;
          q <= qnx;
          if (cnt == '0) begin
            state     <= DONE;
            quotient  <= qnx;
            remainder <= pnx;
            dbz       <= (d == '0);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (start) begin
            a   <= dividend;
            d   <= divisor;
            p   <= '0;
            q   <= '0;
            cnt <= CW'(WIDTH - 1);
`ifdef SEQDIV_DBZ_EARLY_EN
            if (divisor == '0) begin
              state     <= DONE;
              quotient  <= '1;
              remainder <= dividend;
              dbz       <= 1'b1;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
